// File: rtl/slave_arbiter_b_rr.sv
// AXI write-response (B) arbiter and mux: NUM_SLV slave B channels onto one master
// B port. The grant is held until the B handshake, with round-robin or fixed priority.
module slave_arbiter_b_rr #(
  parameter  int unsigned NUM_SLV  = 3,
  parameter  int unsigned ID_W     = 4,
  parameter  int unsigned ARB_MODE = 0,
  localparam int unsigned GNT_W    = $clog2(NUM_SLV)
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [NUM_SLV-1:0]      s_bvalid,
  input  logic [2*NUM_SLV-1:0]    s_bresp,
  input  logic [ID_W*NUM_SLV-1:0] s_bid,
  output logic [NUM_SLV-1:0]      s_bready,
  output logic                    m_bvalid,
  output logic [1:0]              m_bresp,
  output logic [ID_W-1:0]         m_bid,
  input  logic                    m_bready,
  output logic [NUM_SLV-1:0]      bvalid_sel,
  output logic [GNT_W-1:0]        gnt_id,
  output logic                    gnt_active
);

  typedef enum logic {IDLE, GRANT} state_e;

  typedef struct packed {
    logic             found;
    logic [GNT_W-1:0] idx;
  } pick_t;

  state_e             state_q;
  logic [NUM_SLV-1:0] sel_q;
  logic [GNT_W-1:0]   gnt_id_q;
  logic [GNT_W-1:0]   rr_ptr_q;
  logic [GNT_W-1:0]   rr_ptr_d;
  logic               gnt_active_q;
  logic               hs;
  logic [NUM_SLV-1:0] req_next;
  pick_t              win_idle;
  pick_t              win_next;

  // First requester at or after ptr (wrapping); plain lowest index in fixed-priority mode.
  function automatic pick_t pick_winner(input logic [NUM_SLV-1:0] req,
                                        input logic [GNT_W-1:0]   ptr);
    pick_t       res;
    int unsigned idx;
    res = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      idx = i;
      if (ARB_MODE == 0) idx = i + 32'(ptr);
      if (idx >= NUM_SLV) idx = idx - NUM_SLV;
      if (!res.found && req[idx[GNT_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[GNT_W-1:0];
      end
    end
    return res;
  endfunction

  // sel_q is zero outside GRANT, so the mux and ready gating need no state check.
  always_comb begin
    m_bvalid = 1'b0;
    m_bresp  = '0;
    m_bid    = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (sel_q[i]) begin
        m_bvalid = s_bvalid[i];
        m_bresp  = s_bresp[2*i +: 2];
        m_bid    = s_bid[ID_W*i +: ID_W];
      end
    end
    s_bready = sel_q & {NUM_SLV{m_bready}};
  end

  always_comb begin
    hs       = m_bvalid & m_bready;
    rr_ptr_d = rr_ptr_q;
    if (ARB_MODE == 0)
      rr_ptr_d = (gnt_id_q == GNT_W'(NUM_SLV - 1)) ? '0 : gnt_id_q + GNT_W'(1);
    req_next = s_bvalid & ~sel_q;
    win_idle = pick_winner(s_bvalid, rr_ptr_q);
    win_next = pick_winner(req_next, rr_ptr_d);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      gnt_id_q     <= '0;
      gnt_active_q <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_idle.found) begin
            state_q      <= GRANT;
            sel_q        <= NUM_SLV'(1) << win_idle.idx;
            gnt_id_q     <= win_idle.idx;
            gnt_active_q <= 1'b1;
          end
        end
        GRANT: begin
          if (hs) begin
            rr_ptr_q <= rr_ptr_d;
            if (win_next.found) begin
              sel_q    <= NUM_SLV'(1) << win_next.idx;
              gnt_id_q <= win_next.idx;
            end else begin
              state_q      <= IDLE;
              sel_q        <= '0;
              gnt_id_q     <= '0;
              gnt_active_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          sel_q        <= '0;
          gnt_id_q     <= '0;
          gnt_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bvalid_sel = sel_q;
  assign gnt_id     = gnt_id_q;
  assign gnt_active = gnt_active_q;

endmodule

// File: tb/tb_slave_arbiter_b_rr.sv
// Directed bench for slave_arbiter_b_rr: round-robin (3 slaves), fixed priority
// (3 slaves) and round-robin with 5 slaves / 6-bit IDs, all on one clock and reset.
module tb_slave_arbiter_b_rr;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [2:0]  rr_bvalid, rr_bready, rr_sel;
  logic [5:0]  rr_bresp;
  logic [11:0] rr_bid;
  logic        rr_mvalid, rr_mready, rr_act;
  logic [1:0]  rr_mresp, rr_gnt;
  logic [3:0]  rr_mbid;

  logic [2:0]  fp_bvalid, fp_bready, fp_sel;
  logic [5:0]  fp_bresp;
  logic [11:0] fp_bid;
  logic        fp_mvalid, fp_mready, fp_act;
  logic [1:0]  fp_mresp, fp_gnt;
  logic [3:0]  fp_mbid;

  logic [4:0]  r5_bvalid, r5_bready, r5_sel;
  logic [9:0]  r5_bresp;
  logic [29:0] r5_bid;
  logic        r5_mvalid, r5_mready, r5_act;
  logic [1:0]  r5_mresp;
  logic [2:0]  r5_gnt;
  logic [5:0]  r5_mbid;

  slave_arbiter_b_rr #(.NUM_SLV(3), .ID_W(4), .ARB_MODE(0)) u_rr (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .s_bvalid(rr_bvalid), .s_bresp(rr_bresp), .s_bid(rr_bid), .s_bready(rr_bready),
    .m_bvalid(rr_mvalid), .m_bresp(rr_mresp), .m_bid(rr_mbid), .m_bready(rr_mready),
    .bvalid_sel(rr_sel), .gnt_id(rr_gnt), .gnt_active(rr_act)
  );

  slave_arbiter_b_rr #(.NUM_SLV(3), .ID_W(4), .ARB_MODE(1)) u_fp (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .s_bvalid(fp_bvalid), .s_bresp(fp_bresp), .s_bid(fp_bid), .s_bready(fp_bready),
    .m_bvalid(fp_mvalid), .m_bresp(fp_mresp), .m_bid(fp_mbid), .m_bready(fp_mready),
    .bvalid_sel(fp_sel), .gnt_id(fp_gnt), .gnt_active(fp_act)
  );

  slave_arbiter_b_rr #(.NUM_SLV(5), .ID_W(6), .ARB_MODE(0)) u_r5 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .s_bvalid(r5_bvalid), .s_bresp(r5_bresp), .s_bid(r5_bid), .s_bready(r5_bready),
    .m_bvalid(r5_mvalid), .m_bresp(r5_mresp), .m_bid(r5_mbid), .m_bready(r5_mready),
    .bvalid_sel(r5_sel), .gnt_id(r5_gnt), .gnt_active(r5_act)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rr(input string tag, input logic [2:0] sel, input logic [1:0] gnt,
                        input logic act, input logic mv, input logic [2:0] rdy);
    chk({tag, ".sel"},  32'(rr_sel),    32'(sel));
    chk({tag, ".gnt"},  32'(rr_gnt),    32'(gnt));
    chk({tag, ".act"},  32'(rr_act),    32'(act));
    chk({tag, ".mvld"}, 32'(rr_mvalid), 32'(mv));
    chk({tag, ".srdy"}, 32'(rr_bready), 32'(rdy));
  endtask

  task automatic chk_fp(input string tag, input logic [2:0] sel, input logic [1:0] gnt,
                        input logic act, input logic mv, input logic [2:0] rdy);
    chk({tag, ".sel"},  32'(fp_sel),    32'(sel));
    chk({tag, ".gnt"},  32'(fp_gnt),    32'(gnt));
    chk({tag, ".act"},  32'(fp_act),    32'(act));
    chk({tag, ".mvld"}, 32'(fp_mvalid), 32'(mv));
    chk({tag, ".srdy"}, 32'(fp_bready), 32'(rdy));
  endtask

  task automatic chk_r5(input string tag, input logic [4:0] sel, input logic [2:0] gnt,
                        input logic act, input logic mv, input logic [4:0] rdy);
    chk({tag, ".sel"},  32'(r5_sel),    32'(sel));
    chk({tag, ".gnt"},  32'(r5_gnt),    32'(gnt));
    chk({tag, ".act"},  32'(r5_act),    32'(act));
    chk({tag, ".mvld"}, 32'(r5_mvalid), 32'(mv));
    chk({tag, ".srdy"}, 32'(r5_bready), 32'(rdy));
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst   = 1'b1;
    rr_bvalid = '0; rr_mready = 1'b0;
    fp_bvalid = '0; fp_mready = 1'b0;
    r5_bvalid = '0; r5_mready = 1'b0;
    rr_bid    = {4'h9, 4'h5, 4'h3};
    rr_bresp  = {2'd2, 2'd0, 2'd1};
    fp_bid    = {4'h9, 4'h5, 4'h3};
    fp_bresp  = {2'd2, 2'd0, 2'd1};
    r5_bid    = {6'h3F, 6'h33, 6'h00, 6'h22, 6'h11};
    r5_bresp  = {2'd1, 2'd3, 2'd0, 2'd2, 2'd1};
    tick();
    tick();
    sys_rst = 1'b0;
    #1;
    chk_rr("rst.rr", 3'b000, 2'd0, 1'b0, 1'b0, 3'b000);
    chk_fp("rst.fp", 3'b000, 2'd0, 1'b0, 1'b0, 3'b000);
    chk_r5("rst.r5", 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000);

    // Single request from slave 1; 1-cycle grant latency
    rr_mready = 1'b1;
    rr_bvalid = 3'b010;
    #1;
    chk_rr("s1.pre", 3'b000, 2'd0, 1'b0, 1'b0, 3'b000);
    tick(); #1;
    chk_rr("s1.gnt", 3'b010, 2'd1, 1'b1, 1'b1, 3'b010);
    chk("s1.bid",  32'(rr_mbid),  32'h5);
    chk("s1.resp", 32'(rr_mresp), 32'h0);
    tick(); rr_bvalid = 3'b000; #1;
    chk_rr("s1.idle", 3'b000, 2'd0, 1'b0, 1'b0, 3'b000);
    // rr_ptr is now 2: with 0 and 2 requesting, slave 2 wins, then 0 back-to-back
    rr_bvalid = 3'b101;
    tick(); #1;
    chk_rr("s1.p2", 3'b100, 2'd2, 1'b1, 1'b1, 3'b100);
    chk("s1.p2.bid",  32'(rr_mbid),  32'h9);
    chk("s1.p2.resp", 32'(rr_mresp), 32'h2);
    tick(); rr_bvalid = 3'b001; #1;
    chk_rr("s1.b2b", 3'b001, 2'd0, 1'b1, 1'b1, 3'b001);
    chk("s1.b2b.bid",  32'(rr_mbid),  32'h3);
    chk("s1.b2b.resp", 32'(rr_mresp), 32'h1);
    tick(); rr_bvalid = 3'b000; #1;
    chk_rr("s1.end", 3'b000, 2'd0, 1'b0, 1'b0, 3'b000);

    // rr_ptr is 1: grant slave 2 then reset while stalled
    rr_mready = 1'b0;
    rr_bvalid = 3'b100;
    tick(); #1;
    chk_rr("rst.gnt", 3'b100, 2'd2, 1'b1, 1'b1, 3'b000);
    sys_rst = 1'b1;
    tick();
    sys_rst   = 1'b0;
    rr_bvalid = 3'b000;
    rr_mready = 1'b1;
    #1;
    chk_rr("rst.abort", 3'b000, 2'd0, 1'b0, 1'b0, 3'b000);

    // All three request from rr_ptr=0: grants 0,1,2 with no gap
    rr_bvalid = 3'b111;
    tick(); #1;
    chk_rr("s2.g0", 3'b001, 2'd0, 1'b1, 1'b1, 3'b001);
    chk("s2.g0.bid", 32'(rr_mbid), 32'h3);
    tick(); rr_bvalid = 3'b110; #1;
    chk_rr("s2.g1", 3'b010, 2'd1, 1'b1, 1'b1, 3'b010);
    chk("s2.g1.bid", 32'(rr_mbid), 32'h5);
    tick(); rr_bvalid = 3'b100; #1;
    chk_rr("s2.g2", 3'b100, 2'd2, 1'b1, 1'b1, 3'b100);
    chk("s2.g2.bid", 32'(rr_mbid), 32'h9);
    tick(); rr_bvalid = 3'b000; #1;
    chk_rr("s2.idle", 3'b000, 2'd0, 1'b0, 1'b0, 3'b000);

    // Stall slave 1 for several cycles while 0 and 2 request: no preemption
    rr_mready = 1'b0;
    rr_bvalid = 3'b010;
    tick(); rr_bvalid = 3'b111; #1;
    chk_rr("s3.g1", 3'b010, 2'd1, 1'b1, 1'b1, 3'b000);
    for (int c = 0; c < 4; c++) begin
      tick(); #1;
      chk_rr("s3.hold", 3'b010, 2'd1, 1'b1, 1'b1, 3'b000);
    end
    rr_mready = 1'b1;
    #1;
    chk_rr("s3.rdy", 3'b010, 2'd1, 1'b1, 1'b1, 3'b010);
    tick(); rr_bvalid = 3'b101; #1;
    chk_rr("s3.n2", 3'b100, 2'd2, 1'b1, 1'b1, 3'b100);
    tick(); rr_bvalid = 3'b001; #1;
    chk_rr("s3.n0", 3'b001, 2'd0, 1'b1, 1'b1, 3'b001);
    tick(); rr_bvalid = 3'b000; #1;
    chk_rr("s3.idle", 3'b000, 2'd0, 1'b0, 1'b0, 3'b000);

    // Fixed priority: after slave 1, slave 0 beats slave 2
    fp_mready = 1'b1;
    fp_bvalid = 3'b110;
    tick(); fp_bvalid = 3'b111; #1;
    chk_fp("fp.g1", 3'b010, 2'd1, 1'b1, 1'b1, 3'b010);
    tick(); fp_bvalid = 3'b101; #1;
    chk_fp("fp.g0", 3'b001, 2'd0, 1'b1, 1'b1, 3'b001);
    chk("fp.g0.bid", 32'(fp_mbid), 32'h3);
    tick(); fp_bvalid = 3'b100; #1;
    chk_fp("fp.g2", 3'b100, 2'd2, 1'b1, 1'b1, 3'b100);
    tick(); fp_bvalid = 3'b000; #1;
    chk_fp("fp.idle", 3'b000, 2'd0, 1'b0, 1'b0, 3'b000);

    // Five slaves: move rr_ptr to 4, then wrap
    r5_mready = 1'b1;
    r5_bvalid = 5'b01000;
    tick(); #1;
    chk_r5("w.g3", 5'b01000, 3'd3, 1'b1, 1'b1, 5'b01000);
    chk("w.g3.bid",  32'(r5_mbid),  32'h33);
    chk("w.g3.resp", 32'(r5_mresp), 32'h3);
    tick(); r5_bvalid = 5'b00000; #1;
    chk_r5("w.idle1", 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000);
    r5_bvalid = 5'b00011;
    tick(); #1;
    chk_r5("w.g0", 5'b00001, 3'd0, 1'b1, 1'b1, 5'b00001);
    chk("w.g0.bid", 32'(r5_mbid), 32'h11);
    tick(); r5_bvalid = 5'b00010; #1;
    chk_r5("w.g1", 5'b00010, 3'd1, 1'b1, 1'b1, 5'b00010);
    chk("w.g1.bid",  32'(r5_mbid),  32'h22);
    chk("w.g1.resp", 32'(r5_mresp), 32'h2);
    tick(); r5_bvalid = 5'b00000; #1;
    chk_r5("w.idle2", 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000);
    r5_bvalid = 5'b10001;
    tick(); #1;
    chk_r5("w.g4", 5'b10000, 3'd4, 1'b1, 1'b1, 5'b10000);
    chk("w.g4.bid", 32'(r5_mbid), 32'h3F);
    tick(); r5_bvalid = 5'b00001; #1;
    chk_r5("w.wrap", 5'b00001, 3'd0, 1'b1, 1'b1, 5'b00001);
    chk("w.wrap.bid", 32'(r5_mbid), 32'h11);
    tick(); r5_bvalid = 5'b00000; #1;
    chk_r5("w.idle3", 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slave_arbiter_b_rr.md
Name: slave_arbiter_b_rr

Overview:
- Parametrised AXI write-response (B) channel arbiter and mux; successor of the fixed 3-slave B arbiter.
- Arbitrates NUM_SLV slave B channels onto one master B port and routes bresp/bid.
- Returns bready to the granted slave only. Holds the grant until the response handshake completes.
- Supports round-robin or fixed priority, and back-to-back grants without an idle cycle.

Parameters:
- NUM_SLV, 3, number of slave B channels (2..16).
- ID_W, 4, BID width.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- GNT_W, $clog2(NUM_SLV), width of the binary grant index (derived, not overridden).

Ports:
- sys_clk  in  1  clock, all logic on rising edge
- sys_rst  in  1  reset, synchronous, active-high
- s_bvalid  in  NUM_SLV  per-slave response valid
- s_bresp  in  2*NUM_SLV  per-slave BRESP; slave i at bits [2i+1:2i]
- s_bid  in  ID_W*NUM_SLV  per-slave BID; slave i at bits [ID_W*i +: ID_W]
- s_bready  out  NUM_SLV  per-slave ready; only the granted bit can be 1
- m_bvalid  out  1  muxed valid to master
- m_bresp  out  2  muxed BRESP
- m_bid  out  ID_W  muxed BID
- m_bready  in  1  master ready
- bvalid_sel  out  NUM_SLV  registered one-hot grant
- gnt_id  out  GNT_W  registered binary grant index
- gnt_active  out  1  a grant is held

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - state=IDLE, bvalid_sel=0, gnt_id=0, gnt_active=0, rr_ptr=0.
  - m_bvalid=0, s_bready=0.
  - Reset mid-transfer aborts the grant unconditionally; no handshake is completed.
- Winner function:
  - Input is a request vector req.
  - ARB_MODE=0: first set bit of req scanning upward from rr_ptr, wrapping from NUM_SLV-1 to 0.
  - ARB_MODE=1: lowest set bit of req; rr_ptr is ignored.
- FSM states: IDLE, GRANT.
- IDLE:
  - If |s_bvalid, latch winner(s_bvalid) into bvalid_sel/gnt_id, set gnt_active=1, go to GRANT.
  - Grant latency is 1 cycle: valid at edge N gives m_bvalid high at cycle N+1.
  - If no request, stay in IDLE.
- GRANT outputs:
  - m_bvalid = s_bvalid[gnt_id]; m_bresp/m_bid are muxed from gnt_id.
  - s_bready[gnt_id] = m_bready; all other s_bready bits = 0.
  - m_bvalid never depends combinationally on m_bready.
- GRANT with handshake (m_bvalid & m_bready):
  - rr_ptr <= (gnt_id == NUM_SLV-1) ? 0 : gnt_id+1.
  - req_next = s_bvalid with bit gnt_id masked.
  - If |req_next: grant winner(req_next), evaluated with the updated rr_ptr, on the same edge; stay in GRANT. This gives one response per cycle when slaves alternate.
  - Else: clear bvalid_sel, gnt_id, gnt_active; go to IDLE.
- GRANT without handshake:
  - Grant held, outputs stable.
  - New requests from other slaves do not preempt.
  - Granted slave deasserting bvalid before the handshake is an AXI violation. The grant is still held and m_bvalid follows s_bvalid.
- Simultaneous events: requests arriving on the handshake edge are included in req_next. The same slave re-requesting is served only after passing through IDLE or after another slave's grant.
- rr_ptr updates only on a handshake in ARB_MODE=0; in ARB_MODE=1 it stays 0.

Test Plan:
- NUM_SLV=3, RR. s_bvalid=3'b010 with bid=5, bresp=0 at cycle 0; m_bready=1 -> cycle 1: m_bvalid=1, m_bid=5, bvalid_sel=3'b010, s_bready=3'b010. Cycle 2: IDLE, rr_ptr=2.
- RR, rr_ptr=0, s_bvalid=3'b111 held (each slave drops its valid after its handshake), m_bready=1 -> grants 0,1,2 on consecutive cycles 1,2,3 with no idle gap. Then IDLE, rr_ptr=0.
- Slave 1 granted, m_bready=0 for 4 cycles while s0 and s2 request -> bvalid_sel stays 3'b010, s_bready=0, no preemption. m_bready=1 -> handshake; next grant is slave 2.
- ARB_MODE=1, s_bvalid=3'b110 then 3'b101 after the first handshake -> slave 1 then slave 0; rr_ptr stays 0.
- sys_rst=1 during GRANT with m_bready=0 -> next cycle all outputs 0, state IDLE, rr_ptr=0.
- NUM_SLV=5, ID_W=6, rr_ptr=4, s_bvalid=5'b00011 -> winner is 0 (wrap), then 1; m_bid matches the slave's BID slice.
